player_anim_controller: RTL and testbench

Sequences the knight's animation state for the player sprite mapper. Samples movement/physics flags once per video frame and produces Player_Status (idle/walk/jump/fall), the walk-cycle frame index and facing direction. Sits between the player motion logic and the sprite colour mapper. All state is updated only on frame ticks.

---
 rtl/anim_pkg.sv | 16 +
 rtl/frame_tick_gen.sv | 26 ++
 rtl/player_anim_controller.sv | 137 +++++++++++++
 tb/tb_player_anim_controller.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/anim_pkg.sv
// Shared types and default constants for the player animation controller.
package anim_pkg;

   typedef enum logic [3:0] {
      IDLE = 4'd0,
      WALK = 4'd1,
      JUMP = 4'd2,
      FALL = 4'd3,
      LAND = 4'd4
   } status_t;

   localparam int unsigned FRAME_DIV_DEF   = 6;
   localparam int unsigned WALK_FRAMES_DEF = 4;
   localparam int unsigned LAND_FRAMES_DEF = 4;

endpackage

// File: rtl/frame_tick_gen.sv
// Rising-edge detector turning the raw frame signal into a one-cycle tick,
// shared by the per-frame controllers.
module frame_tick_gen (
   input  logic Clk,
   input  logic Reset,
   input  logic frame_clk,
   output logic tick
);

   logic frame_clk_q, frame_clk_d;

   always_comb begin
      frame_clk_d = frame_clk;
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         frame_clk_q <= 1'b0;
      end else begin
         frame_clk_q <= frame_clk_d;
      end
   end

   assign tick = frame_clk & ~frame_clk_q;

endmodule

// File: rtl/player_anim_controller.sv
// Per-frame animation sequencer for the player sprite (idle/walk/jump/fall).
// Define ANIM_LAND_EN to add a timed LAND state after touching down.
module player_anim_controller
   import anim_pkg::*;
#(
   parameter int unsigned FRAME_DIV   = FRAME_DIV_DEF,
   parameter int unsigned WALK_FRAMES = WALK_FRAMES_DEF,
   parameter int unsigned LAND_FRAMES = LAND_FRAMES_DEF
) (
   input  logic       Clk,
   input  logic       Reset,
   input  logic       frame_clk,
   input  logic       on_ground,
   input  logic [9:0] Vel_Y,
   input  logic       move_left,
   input  logic       move_right,
   output logic [3:0] Player_Status,
   output logic [1:0] Walk_Frame,
   output logic       Facing_Left,
   output logic       Status_Change
);

   localparam logic [3:0] DivLast  = 4'(FRAME_DIV - 1);
   localparam logic [1:0] WalkLast = 2'(WALK_FRAMES - 1);

   if (FRAME_DIV < 1 || FRAME_DIV > 15 || WALK_FRAMES < 2 || WALK_FRAMES > 4 ||
       LAND_FRAMES < 1 || LAND_FRAMES > 16) begin : g_param_check
      $error("player_anim_controller: parameter out of range");
   end

   logic       tick;
   logic       dir;
   logic       vel_up;
   status_t    grounded_st;
   status_t    state_q, state_d;
   logic [3:0] div_q, div_d;
   logic [1:0] walk_frame_q, walk_frame_d;
   logic       facing_left_q, facing_left_d;
   logic       status_change_q, status_change_d;

`ifdef ANIM_LAND_EN
   localparam logic [3:0] LandLast = 4'(LAND_FRAMES - 1);
   logic [3:0] land_cnt_q, land_cnt_d;
`endif

   frame_tick_gen u_frame_tick_gen (
      .Clk      (Clk),
      .Reset    (Reset),
      .frame_clk(frame_clk),
      .tick     (tick)
   );

   assign dir         = move_left ^ move_right;
   assign vel_up      = $signed(Vel_Y) < 10'sd0;
   assign grounded_st = dir ? WALK : IDLE;

   always_comb begin
      state_d         = state_q;
      div_d           = div_q;
      walk_frame_d    = walk_frame_q;
      facing_left_d   = facing_left_q;
      status_change_d = 1'b0;
`ifdef ANIM_LAND_EN
      land_cnt_d      = land_cnt_q;
`endif
      if (tick) begin
         // Airborne takes priority over any key input.
         if (!on_ground) begin
            state_d = vel_up ? JUMP : FALL;
         end else begin
            case (state_q)
`ifdef ANIM_LAND_EN
               JUMP, FALL: state_d = LAND;
               LAND:       state_d = (land_cnt_q == 4'd0) ? grounded_st : LAND;
`else
               JUMP, FALL: state_d = grounded_st;
`endif
               default:    state_d = grounded_st;
            endcase
         end

`ifdef ANIM_LAND_EN
         if (state_d == LAND) begin
            land_cnt_d = (state_q == LAND) ? land_cnt_q - 4'd1 : LandLast;
         end else begin
            land_cnt_d = 4'd0;
         end
`endif

         // Divider only runs while staying in WALK; any entry restarts the cycle.
         if (state_d == WALK && state_q == WALK) begin
            if (div_q == DivLast) begin
               div_d        = 4'd0;
               walk_frame_d = (walk_frame_q == WalkLast) ? 2'd0 : walk_frame_q + 2'd1;
            end else begin
               div_d = div_q + 4'd1;
            end
         end else begin
            div_d        = 4'd0;
            walk_frame_d = 2'd0;
         end

         if (dir) begin
            facing_left_d = move_left;
         end
         status_change_d = (state_d != state_q);
      end
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         state_q         <= IDLE;
         div_q           <= 4'd0;
         walk_frame_q    <= 2'd0;
         facing_left_q   <= 1'b0;
         status_change_q <= 1'b0;
`ifdef ANIM_LAND_EN
         land_cnt_q      <= 4'd0;
`endif
      end else begin
         state_q         <= state_d;
         div_q           <= div_d;
         walk_frame_q    <= walk_frame_d;
         facing_left_q   <= facing_left_d;
         status_change_q <= status_change_d;
`ifdef ANIM_LAND_EN
         land_cnt_q      <= land_cnt_d;
`endif
      end
   end

   assign Player_Status = state_q;
   assign Walk_Frame    = walk_frame_q;
   assign Facing_Left   = facing_left_q;
   assign Status_Change = status_change_q;

endmodule

// File: tb/tb_player_anim_controller.sv
// Scoreboard bench for player_anim_controller: a behavioural model pushes the
// expected outputs per tick, and they are popped when the DUT registers them.
module tb_player_anim_controller;

   localparam int unsigned FD = 6;
   localparam int unsigned WF = 4;
   localparam int unsigned LF = 4;

   typedef struct {
      int st;
      int wf;
      int face;
      int chg;
   } exp_t;

   logic       clk;
   logic       reset;
   logic       frame_clk;
   logic       on_ground;
   logic [9:0] vel_y;
   logic       move_left;
   logic       move_right;
   logic [3:0] player_status;
   logic [1:0] walk_frame;
   logic       facing_left;
   logic       status_change;

   int   n_total;
   int   n_bad;
   exp_t sb[$];
   exp_t last;

   int m_st, m_wf, m_div, m_face, m_land;

   player_anim_controller #(
      .FRAME_DIV  (FD),
      .WALK_FRAMES(WF),
      .LAND_FRAMES(LF)
   ) dut (
      .Clk          (clk),
      .Reset        (reset),
      .frame_clk    (frame_clk),
      .on_ground    (on_ground),
      .Vel_Y        (vel_y),
      .move_left    (move_left),
      .move_right   (move_right),
      .Player_Status(player_status),
      .Walk_Frame   (walk_frame),
      .Facing_Left  (facing_left),
      .Status_Change(status_change)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input int got, input int exp);
      n_total++;
      if (got != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic model_reset();
      m_st = 0; m_wf = 0; m_div = 0; m_face = 0; m_land = 0;
      last = '{st: 0, wf: 0, face: 0, chg: 0};
      sb.delete();
   endtask

   // Reference behaviour for one frame tick; pushes the expected outputs.
   task automatic model_step(input logic og, input logic [9:0] vel, input logic ml,
                             input logic mr);
      int   nxt;
      logic dir;
      exp_t e;
      dir = ml ^ mr;
      if (!og) nxt = vel[9] ? 2 : 3;
`ifdef ANIM_LAND_EN
      else if (m_st == 2 || m_st == 3) nxt = 4;
      else if (m_st == 4) nxt = (m_land == 0) ? (dir ? 1 : 0) : 4;
`else
      else if (m_st == 2 || m_st == 3) nxt = dir ? 1 : 0;
`endif
      else nxt = dir ? 1 : 0;

      if (nxt == 4) m_land = (m_st == 4) ? m_land - 1 : int'(LF) - 1;
      else m_land = 0;

      if (nxt == 1 && m_st == 1) begin
         if (m_div == int'(FD) - 1) begin
            m_div = 0;
            m_wf  = (m_wf + 1) % int'(WF);
         end else begin
            m_div++;
         end
      end else begin
         m_div = 0;
         m_wf  = 0;
      end

      if (dir) m_face = ml ? 1 : 0;
      e.chg = (nxt != m_st) ? 1 : 0;
      m_st  = nxt;
      e.st  = m_st;
      e.wf  = m_wf;
      e.face = m_face;
      sb.push_back(e);
   endtask

   task automatic pop_check(input string tag);
      exp_t e;
      if (sb.size() == 0) begin
         chk({tag, "_sb_underflow"}, sb.size(), 1);
      end else begin
         e = sb.pop_front();
         chk({tag, "_status"}, int'(player_status), e.st);
         chk({tag, "_wframe"}, int'(walk_frame), e.wf);
         chk({tag, "_facing"}, int'(facing_left), e.face);
         chk({tag, "_change"}, int'(status_change), e.chg);
         last = e;
      end
   endtask

   task automatic do_tick(input string tag, input logic og, input logic [9:0] vel,
                          input logic ml, input logic mr);
      @(negedge clk);
      on_ground  = og;
      vel_y      = vel;
      move_left  = ml;
      move_right = mr;
      frame_clk  = 1'b1;
      model_step(og, vel, ml, mr);
      @(posedge clk);
      #1;
      pop_check(tag);
      @(negedge clk);
      frame_clk = 1'b0;
      @(posedge clk);
      #1;
      chk({tag, "_chg_clear"}, int'(status_change), 0);
      chk({tag, "_hold"}, int'(player_status), last.st);
   endtask

   initial begin
      n_total    = 0;
      n_bad      = 0;
      reset      = 1'b1;
      frame_clk  = 1'b0;
      on_ground  = 1'b1;
      vel_y      = 10'd0;
      move_left  = 1'b0;
      move_right = 1'b0;
      model_reset();

      // Reset held with frame_clk toggling.
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         frame_clk  = ~frame_clk;
         move_right = 1'b1;
         @(posedge clk);
         #1;
         chk("rst_status", int'(player_status), 0);
         chk("rst_wframe", int'(walk_frame), 0);
         chk("rst_facing", int'(facing_left), 0);
         chk("rst_change", int'(status_change), 0);
      end
      @(negedge clk);
      reset      = 1'b0;
      frame_clk  = 1'b0;
      move_right = 1'b0;
      @(posedge clk);
      #1;

      // Walk right 13 ticks.
      for (int i = 0; i < 13; i++) do_tick("walk", 1'b1, 10'd0, 1'b0, 1'b1);
      chk("walk13_status", int'(player_status), 1);
      chk("walk13_wframe", int'(walk_frame), 2);

      // Jump, then fall, then touch down with no keys.
      do_tick("jump", 1'b0, -10'sd5, 1'b0, 1'b0);
      do_tick("jump", 1'b0, -10'sd5, 1'b0, 1'b0);
      do_tick("fall", 1'b0, 10'd3, 1'b0, 1'b0);
      chk("air_status", int'(player_status), 3);
      for (int i = 0; i < 5; i++) do_tick("land", 1'b1, 10'd0, 1'b0, 1'b0);
      chk("land_done", int'(player_status), 0);

      // Both keys on ground is no intent.
      do_tick("both", 1'b1, 10'd0, 1'b1, 1'b1);
      do_tick("both", 1'b1, 10'd0, 1'b1, 1'b1);
      chk("both_facing", int'(facing_left), 0);

      // Left key while airborne flips facing but does not leave FALL.
      do_tick("airleft", 1'b0, 10'd3, 1'b1, 1'b0);
      chk("airleft_facing", int'(facing_left), 1);
      chk("airleft_status", int'(player_status), 3);
      for (int i = 0; i < 5; i++) do_tick("touch", 1'b1, 10'd0, 1'b0, 1'b0);

      // Walk 9, stop 1, walk again: divider restarts.
      for (int i = 0; i < 9; i++) do_tick("walk9", 1'b1, 10'd0, 1'b0, 1'b1);
      do_tick("stop", 1'b1, 10'd0, 1'b0, 1'b0);
      for (int i = 0; i < 7; i++) do_tick("rewalk", 1'b1, 10'd0, 1'b0, 1'b1);
      chk("rewalk_wframe", int'(walk_frame), 1);

      // frame_clk held high for 20 cycles: one update only.
      @(negedge clk);
      on_ground  = 1'b1;
      move_left  = 1'b1;
      move_right = 1'b0;
      frame_clk  = 1'b1;
      model_step(1'b1, 10'd0, 1'b1, 1'b0);
      @(posedge clk);
      #1;
      pop_check("held_first");
      for (int i = 1; i < 20; i++) begin
         @(negedge clk);
         move_left  = i[0];
         move_right = i[1];
         on_ground  = ~i[2];
         @(posedge clk);
         #1;
         chk("held_status", int'(player_status), last.st);
         chk("held_facing", int'(facing_left), last.face);
         chk("held_change", int'(status_change), 0);
      end
      @(negedge clk);
      frame_clk = 1'b0;
      @(posedge clk);
      #1;

      // Build up state, then reset on the same cycle as a tick.
      for (int i = 0; i < 8; i++) do_tick("preload", 1'b1, 10'd0, 1'b1, 1'b0);
      @(negedge clk);
      reset     = 1'b1;
      frame_clk = 1'b1;
      @(posedge clk);
      #1;
      model_reset();
      chk("rst_tick_status", int'(player_status), 0);
      chk("rst_tick_wframe", int'(walk_frame), 0);
      chk("rst_tick_facing", int'(facing_left), 0);
      chk("rst_tick_change", int'(status_change), 0);
      @(negedge clk);
      reset     = 1'b0;
      frame_clk = 1'b0;
      @(posedge clk);
      #1;
      chk("post_rst_status", int'(player_status), 0);

      // Random mix of ground/air and keys.
      for (int i = 0; i < 60; i++) begin
         do_tick("rand", ($urandom_range(0, 3) != 0), 10'($urandom),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      end

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
